// File: rtl/detector_colision_pkg.sv
// Shared definitions for the game blocks: top-level state codes, game-result
// encodings and the collision detector's internal state type.
package detector_colision_pkg;

  localparam logic [2:0] ST_OFF  = 3'd0;
  localparam logic [2:0] ST_WLCM = 3'd1;
  localparam logic [2:0] ST_CH   = 3'd2;
  localparam logic [2:0] ST_GAME = 3'd3;
  localparam logic [2:0] ST_WL   = 3'd4;
  localparam logic [2:0] ST_PA   = 3'd5;

  localparam logic [1:0] JUGANDO_C = 2'b00;
  localparam logic [1:0] PERDIO_C  = 2'b01;
  localparam logic [1:0] GANO_C    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_JUGANDO,
    S_GRACIA,
    S_PERDIO,
    S_GANO
  } estado_t;

  // The score never wraps back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sinc_flanco.sv
// Two-flop synchronizer for a slow asynchronous clock-like signal, producing a
// one-clk pulse per rising edge seen in the clk domain.
module sinc_flanco (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulso
);

  logic sync0_q, sync1_q, prev_q;
  logic sync0_d, sync1_d, prev_d;

  always_comb begin
    sync0_d = din;
    sync1_d = sync0_q;
    prev_d  = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
    end
  end

  assign pulso = sync1_q & ~prev_q;

endmodule

// File: rtl/detector_colision.sv
// Collision detector: compares the hero against the leftmost obstacle digit,
// tracks lives and score, and reports the game result.
module detector_colision
  import detector_colision_pkg::*;
#(
  parameter int         VIDAS  = 3,
  parameter logic [7:0] META   = 8'd30,
  parameter int         GRACIA = 2,
  parameter logic [2:0] GAME   = 3'd3,
  parameter logic [2:0] WL     = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  presente,
  input  logic        clk_obstaculos,
  input  logic [20:0] display_obs,
  input  logic [6:0]  heroe_seg,
  output logic [1:0]  W_or_L,
  output logic [1:0]  vidas,
  output logic [7:0]  puntaje,
  output logic        golpe
);

  localparam logic [1:0] VIDAS_INI  = 2'(VIDAS);
  localparam logic [2:0] GRACIA_INI = 3'(GRACIA);

  estado_t    estado_q, estado_d;
  logic [1:0] vidas_q, vidas_d;
  logic [7:0] puntaje_q, puntaje_d;
  logic [1:0] w_or_l_q, w_or_l_d;
  logic       golpe_q, golpe_d;
  logic       pendiente_q, pendiente_d;
  logic [2:0] gracia_q, gracia_d;

  logic       tick;
  logic       hit;
  logic [7:0] puntaje_inc;
  logic       unused_digitos;

  sinc_flanco u_sinc_obs (
    .clk   (clk),
    .rst   (rst),
    .din   (clk_obstaculos),
    .pulso (tick)
  );

  assign hit            = |(display_obs[6:0] & heroe_seg);
  assign puntaje_inc    = sat_inc(puntaje_q);
  assign unused_digitos = ^display_obs[20:7];

  // pendiente remembers that the digit now under the hero was a real obstacle,
  // so the next tick (it scrolling away untouched) earns a point.
  always_comb begin
    estado_d    = estado_q;
    vidas_d     = vidas_q;
    puntaje_d   = puntaje_q;
    w_or_l_d    = w_or_l_q;
    golpe_d     = 1'b0;
    pendiente_d = pendiente_q;
    gracia_d    = gracia_q;

    unique case (estado_q)
      S_IDLE: begin
        if (presente == GAME) begin
          estado_d    = S_JUGANDO;
          vidas_d     = VIDAS_INI;
          puntaje_d   = 8'd0;
          pendiente_d = 1'b0;
          w_or_l_d    = JUGANDO_C;
        end
      end

      S_JUGANDO: begin
        if (presente != GAME) begin
          estado_d    = S_IDLE;
          vidas_d     = 2'd0;
          puntaje_d   = 8'd0;
          w_or_l_d    = JUGANDO_C;
          pendiente_d = 1'b0;
          gracia_d    = 3'd0;
        end else if (hit) begin
          golpe_d     = 1'b1;
          pendiente_d = 1'b0;
          if (vidas_q <= 2'd1) begin
            estado_d = S_PERDIO;
            vidas_d  = 2'd0;
            w_or_l_d = PERDIO_C;
          end else begin
            estado_d = S_GRACIA;
            vidas_d  = vidas_q - 2'd1;
            gracia_d = GRACIA_INI;
          end
        end else if (tick) begin
          if (pendiente_q) begin
            puntaje_d = puntaje_inc;
            if (puntaje_inc == META) begin
              estado_d = S_GANO;
              w_or_l_d = GANO_C;
            end
          end
          pendiente_d = |display_obs[6:0];
        end
      end

      S_GRACIA: begin
        if (presente != GAME) begin
          estado_d    = S_IDLE;
          vidas_d     = 2'd0;
          puntaje_d   = 8'd0;
          w_or_l_d    = JUGANDO_C;
          pendiente_d = 1'b0;
          gracia_d    = 3'd0;
        end else if (tick) begin
          gracia_d    = gracia_q - 3'd1;
          pendiente_d = 1'b0;
          if (gracia_q <= 3'd1) begin
            estado_d = S_JUGANDO;
            gracia_d = 3'd0;
          end
        end
      end

      S_PERDIO, S_GANO: begin
        if ((presente != GAME) && (presente != WL)) begin
          estado_d    = S_IDLE;
          vidas_d     = 2'd0;
          puntaje_d   = 8'd0;
          w_or_l_d    = JUGANDO_C;
          pendiente_d = 1'b0;
          gracia_d    = 3'd0;
        end
      end

      default: begin
        estado_d    = S_IDLE;
        vidas_d     = 2'd0;
        puntaje_d   = 8'd0;
        w_or_l_d    = JUGANDO_C;
        pendiente_d = 1'b0;
        gracia_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= S_IDLE;
      vidas_q     <= 2'd0;
      puntaje_q   <= 8'd0;
      w_or_l_q    <= JUGANDO_C;
      golpe_q     <= 1'b0;
      pendiente_q <= 1'b0;
      gracia_q    <= 3'd0;
    end else begin
      estado_q    <= estado_d;
      vidas_q     <= vidas_d;
      puntaje_q   <= puntaje_d;
      w_or_l_q    <= w_or_l_d;
      golpe_q     <= golpe_d;
      pendiente_q <= pendiente_d;
      gracia_q    <= gracia_d;
    end
  end

  assign W_or_L  = w_or_l_q;
  assign vidas   = vidas_q;
  assign puntaje = puntaje_q;
  assign golpe   = golpe_q;

endmodule

// File: tb/tb_detector_colision.sv
// Directed bench for detector_colision: scoring, hits with grace, loss/win
// latching, simultaneous events, aborts and asynchronous reset.
module tb_detector_colision;
  import detector_colision_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  presente;
  logic        clk_obstaculos;
  logic [20:0] display_obs;
  logic [6:0]  heroe_seg;
  logic [1:0]  W_or_L;
  logic [1:0]  vidas;
  logic [7:0]  puntaje;
  logic        golpe;

  int checks = 0;
  int errors = 0;

  detector_colision dut (
    .clk            (clk),
    .rst            (rst),
    .presente       (presente),
    .clk_obstaculos (clk_obstaculos),
    .display_obs    (display_obs),
    .heroe_seg      (heroe_seg),
    .W_or_L         (W_or_L),
    .vidas          (vidas),
    .puntaje        (puntaje),
    .golpe          (golpe)
  );

  always #5 clk = ~clk;

  // The FSM acts on the third rising clk edge after clk_obstaculos rises.
  task automatic tick_rise();
    clk_obstaculos = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick_fall();
    clk_obstaculos = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    presente = ST_OFF;
    clk_obstaculos = 1'b0;
    display_obs = 21'h0;
    heroe_seg = 7'h00;
    repeat (2) @(negedge clk);
    checks++; if (vidas !== 2'd0) begin errors++; $display("[TB] FAIL reset_vidas got %0d want 0", vidas); end
    checks++; if (puntaje !== 8'd0) begin errors++; $display("[TB] FAIL reset_puntaje got %0d want 0", puntaje); end
    checks++; if (W_or_L !== 2'b00) begin errors++; $display("[TB] FAIL reset_wl got %b want 00", W_or_L); end
    checks++; if (golpe !== 1'b0) begin errors++; $display("[TB] FAIL reset_golpe got %b want 0", golpe); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vidas !== 2'd0) begin errors++; $display("[TB] FAIL idle_vidas got %0d want 0", vidas); end
    presente = ST_GAME;
    @(negedge clk);
    checks++; if (vidas !== 2'd3) begin errors++; $display("[TB] FAIL start_vidas got %0d want 3", vidas); end
    checks++; if (puntaje !== 8'd0) begin errors++; $display("[TB] FAIL start_puntaje got %0d want 0", puntaje); end
    checks++; if (W_or_L !== 2'b00) begin errors++; $display("[TB] FAIL start_wl got %b want 00", W_or_L); end
  endtask

  task automatic test_score_win();
    display_obs = {14'h2A5A, 7'h08};
    heroe_seg = 7'h01;
    for (int i = 1; i <= 30; i++) begin
      tick_rise();
      checks++; if (puntaje !== 8'(i - 1)) begin errors++; $display("[TB] FAIL score_tick%0d got %0d want %0d", i, puntaje, i - 1); end
      tick_fall();
    end
    clk_obstaculos = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (W_or_L !== 2'b00) begin errors++; $display("[TB] FAIL win_early got %b want 00", W_or_L); end
    @(negedge clk);
    checks++; if (W_or_L !== 2'b10) begin errors++; $display("[TB] FAIL win_wl got %b want 10", W_or_L); end
    checks++; if (puntaje !== 8'd30) begin errors++; $display("[TB] FAIL win_puntaje got %0d want 30", puntaje); end
    checks++; if (vidas !== 2'd3) begin errors++; $display("[TB] FAIL win_vidas got %0d want 3", vidas); end
    tick_fall();
    heroe_seg = 7'h08;
    tick_rise();
    tick_fall();
    checks++; if (puntaje !== 8'd30) begin errors++; $display("[TB] FAIL win_freeze_puntaje got %0d want 30", puntaje); end
    checks++; if (vidas !== 2'd3) begin errors++; $display("[TB] FAIL win_freeze_vidas got %0d want 3", vidas); end
    presente = ST_WL;
    repeat (2) @(negedge clk);
    checks++; if (W_or_L !== 2'b10) begin errors++; $display("[TB] FAIL win_hold_wl got %b want 10", W_or_L); end
    presente = ST_WLCM;
    @(negedge clk);
    checks++; if (W_or_L !== 2'b00) begin errors++; $display("[TB] FAIL win_leave_wl got %b want 00", W_or_L); end
    checks++; if (puntaje !== 8'd0) begin errors++; $display("[TB] FAIL win_leave_puntaje got %0d want 0", puntaje); end
  endtask

  task automatic test_hits_lose();
    display_obs = {14'h155A, 7'h08};
    heroe_seg = 7'h01;
    presente = ST_GAME;
    @(negedge clk);
    heroe_seg = 7'h08;
    @(negedge clk);
    checks++; if (golpe !== 1'b1) begin errors++; $display("[TB] FAIL hit1_golpe got %b want 1", golpe); end
    checks++; if (vidas !== 2'd2) begin errors++; $display("[TB] FAIL hit1_vidas got %0d want 2", vidas); end
    @(negedge clk);
    checks++; if (golpe !== 1'b0) begin errors++; $display("[TB] FAIL hit1_pulse got %b want 0", golpe); end
    tick_rise();
    tick_fall();
    checks++; if (vidas !== 2'd2) begin errors++; $display("[TB] FAIL grace1_vidas got %0d want 2", vidas); end
    tick_rise();
    checks++; if (vidas !== 2'd2) begin errors++; $display("[TB] FAIL grace2_vidas got %0d want 2", vidas); end
    @(negedge clk);
    checks++; if (vidas !== 2'd1) begin errors++; $display("[TB] FAIL hit2_vidas got %0d want 1", vidas); end
    checks++; if (golpe !== 1'b1) begin errors++; $display("[TB] FAIL hit2_golpe got %b want 1", golpe); end
    tick_fall();
    tick_rise();
    tick_fall();
    tick_rise();
    @(negedge clk);
    checks++; if (vidas !== 2'd0) begin errors++; $display("[TB] FAIL hit3_vidas got %0d want 0", vidas); end
    checks++; if (W_or_L !== 2'b01) begin errors++; $display("[TB] FAIL hit3_wl got %b want 01", W_or_L); end
    presente = ST_WL;
    repeat (3) @(negedge clk);
    checks++; if (W_or_L !== 2'b01) begin errors++; $display("[TB] FAIL lose_hold_wl got %b want 01", W_or_L); end
    presente = ST_WLCM;
    @(negedge clk);
    checks++; if (W_or_L !== 2'b00) begin errors++; $display("[TB] FAIL lose_leave_wl got %b want 00", W_or_L); end
    checks++; if (vidas !== 2'd0) begin errors++; $display("[TB] FAIL lose_leave_vidas got %0d want 0", vidas); end
    tick_fall();
  endtask

  task automatic test_simultaneous();
    display_obs = {14'h0000, 7'h08};
    heroe_seg = 7'h01;
    presente = ST_GAME;
    @(negedge clk);
    heroe_seg = 7'h08;
    @(negedge clk);
    tick_rise();
    tick_fall();
    tick_rise();
    @(negedge clk);
    heroe_seg = 7'h01;
    checks++; if (vidas !== 2'd1) begin errors++; $display("[TB] FAIL simul_setup_vidas got %0d want 1", vidas); end
    tick_fall();
    for (int i = 0; i < 32; i++) begin
      tick_rise();
      tick_fall();
    end
    checks++; if (puntaje !== 8'd29) begin errors++; $display("[TB] FAIL simul_setup_puntaje got %0d want 29", puntaje); end
    clk_obstaculos = 1'b1;
    repeat (2) @(negedge clk);
    heroe_seg = 7'h08;
    @(negedge clk);
    checks++; if (W_or_L !== 2'b01) begin errors++; $display("[TB] FAIL simul_wl got %b want 01", W_or_L); end
    checks++; if (puntaje !== 8'd29) begin errors++; $display("[TB] FAIL simul_puntaje got %0d want 29", puntaje); end
    checks++; if (vidas !== 2'd0) begin errors++; $display("[TB] FAIL simul_vidas got %0d want 0", vidas); end
    tick_fall();
    presente = ST_WLCM;
    @(negedge clk);
  endtask

  task automatic test_reset_grace();
    display_obs = {14'h0000, 7'h08};
    heroe_seg = 7'h01;
    presente = ST_GAME;
    @(negedge clk);
    heroe_seg = 7'h08;
    @(negedge clk);
    checks++; if (vidas !== 2'd2) begin errors++; $display("[TB] FAIL rstg_setup_vidas got %0d want 2", vidas); end
    #2 rst = 1'b1;
    #1;
    checks++; if (vidas !== 2'd0) begin errors++; $display("[TB] FAIL rstg_vidas got %0d want 0", vidas); end
    checks++; if (golpe !== 1'b0) begin errors++; $display("[TB] FAIL rstg_golpe got %b want 0", golpe); end
    checks++; if (W_or_L !== 2'b00) begin errors++; $display("[TB] FAIL rstg_wl got %b want 00", W_or_L); end
    @(negedge clk);
    rst = 1'b0;
    heroe_seg = 7'h01;
    @(negedge clk);
    checks++; if (vidas !== 2'd3) begin errors++; $display("[TB] FAIL rstg_restart_vidas got %0d want 3", vidas); end
    checks++; if (puntaje !== 8'd0) begin errors++; $display("[TB] FAIL rstg_restart_puntaje got %0d want 0", puntaje); end
  endtask

  task automatic test_abort();
    presente = ST_CH;
    @(negedge clk);
    checks++; if (vidas !== 2'd0) begin errors++; $display("[TB] FAIL abort_vidas got %0d want 0", vidas); end
    checks++; if (W_or_L !== 2'b00) begin errors++; $display("[TB] FAIL abort_wl got %b want 00", W_or_L); end
  endtask

  initial begin
    test_reset();
    test_score_win();
    test_hits_lose();
    test_simultaneous();
    test_reset_grace();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_colision.md
Name: detector_colision

Overview:
- Downstream consumer of the obstacle generator's scrolling digits `display_obs` and `clk_obstaculos`.
- Compares the hero's lit segments against the leftmost obstacle digit and counts lives and score.
- Produces the `W_or_L` game-result code that the generator and the top-level state machine use to freeze and leave the GAME state.

Parameters:
- VIDAS, 3: lives loaded at game start (1..3).
- META, 8'd30: obstacles dodged needed to win.
- GRACIA, 2: obstacle ticks of invulnerability after a hit (1..7).
- GAME, 3'd3: game-state code on `presente`.
- WL, 3'd4: win/lose display-state code on `presente`.

Ports:
- clk  in  1  system clock (27 MHz).
- rst  in  1  asynchronous, active-high reset.
- presente  in  3  current top-level state.
- clk_obstaculos  in  1  obstacle scroll clock from the generator (slow, about 50% duty).
- display_obs  in  21  obstacle digits; [6:0] is the leftmost (hero) digit.
- heroe_seg  in  7  segments currently occupied by the hero.
- W_or_L  out  2  00 playing/idle, 01 lost, 10 won; 11 never driven.
- vidas  out  2  remaining lives.
- puntaje  out  8  obstacles dodged, binary.
- golpe  out  1  one-clk pulse on each counted hit.

Behaviour:
- All logic runs on `clk`. `rst` asynchronously forces the following; the first edge after release is the first active one.
  - state=IDLE, `W_or_L`=00, `vidas`=0, `puntaje`=0, `golpe`=0.
  - Sync flops=0, `pendiente`=0, grace counter=0.
- Tick generation:
  - `clk_obstaculos` passes through a 2-FF synchronizer plus a previous-value flop.
  - `tick` = sync1 & ~prev: a one-clk pulse, 2–3 clk after each rising edge of `clk_obstaculos`.
- Hit condition: `hit` = |(display_obs[6:0] & heroe_seg), evaluated every clk.
- States: IDLE, JUGANDO, GRACIA, PERDIO, GANO.
- IDLE:
  - Outputs held at reset values.
  - `presente`==GAME → JUGANDO next clk; load `vidas`=VIDAS, `puntaje`=0, `pendiente`=0.
- JUGANDO, evaluated in this priority order:
  1. `hit`:
     - `golpe`=1 for one clk; `vidas` decrements; `pendiente` clears.
     - If `vidas` was 1 → PERDIO, `vidas`=0.
     - Otherwise → GRACIA, grace counter=GRACIA.
  2. Else `tick`:
     - If `pendiente`, `puntaje` increments; reaching META → GANO.
     - `pendiente` then loads (display_obs[6:0]!=0) for the digit now in the hero position.
- GRACIA:
  - `hit` is ignored.
  - On `tick`: grace counter decrements, and `pendiente` is forced to 0 (no score during grace).
  - Counter reaching 0 on a tick → JUGANDO.
- Simultaneous events:
  - `hit` and `tick` on the same clk: the hit wins, no score that cycle.
  - A hit on the last life overrides a win on the same clk.
- PERDIO: `W_or_L`=01. GANO: `W_or_L`=10. `vidas` and `puntaje` are frozen in both.
- Leaving a game:
  - In PERDIO/GANO, the result and counters hold while `presente` is GAME or WL.
  - Any other `presente` → IDLE with all outputs cleared.
  - From JUGANDO/GRACIA, `presente`!=GAME → IDLE immediately; this is the abort path.
- `puntaje` saturates at 8'hFF (only reachable with META > 255, which is illegal); no wrap.
- `W_or_L` is registered and changes exactly one clk after the deciding event.

Decomposition:
- Shared package holds:
  - The state codes OFF/WLCM/CH/GAME/WL/PA used by every game block.
  - The W_or_L encodings: JUGANDO_C=2'b00, PERDIO_C=2'b01, GANO_C=2'b10.
- One sub-module, `sinc_flanco`: a 2-FF synchronizer with rising-edge pulse output, parameterless, async active-high reset.
  - Reused by any block that samples `clk_obstaculos` or `clk_1hz`.

Test Plan:
- Reset released, then `presente`=GAME → `vidas`=3, `puntaje`=0, `W_or_L`=00, state JUGANDO within 1 clk.
- display_obs[6:0]=7'h08, `heroe_seg`=7'h01 across 30 ticks, with each tick carrying a nonzero leftmost digit → `puntaje` counts to 30 and `W_or_L`=10 one clk after the 31st tick; counters freeze.
- `heroe_seg`=7'h08 overlapping digit 7'h08 → `golpe` is one clk, `vidas` 3→2. Overlap held for 2 more ticks gives no further decrement (GRACIA=2). Hit after grace → `vidas`=1.
- Third hit → `vidas`=0, `W_or_L`=01. `presente`=WL → still 01. `presente`=WLCM → 00, `vidas`=0, IDLE.
- With `puntaje`=29 and `vidas`=1, force `hit` and `tick` on the same clk → `W_or_L`=01, `puntaje` stays 29.
- Assert `rst` mid-GRACIA, asynchronously between clk edges → all outputs 0 immediately; after release with `presente`=GAME, a fresh game starts with `vidas`=3.
